led_mode_scheduler: RTL

//  Pattern controller for the board LEDs (8-bit led bar + four RGB ld1..ld4).

---
 rtl/led_mode_scheduler_if.sv | 25 ++
 rtl/led_mode_scheduler.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/led_mode_scheduler_if.sv
// LED pattern scheduler port bundle.
// Master drives requests; slave returns LED state.
interface led_mode_scheduler_if;
  logic       mode_req;
  logic       pause;
  logic [7:0] led;
  logic [2:0] ld1;
  logic [2:0] ld2;
  logic [2:0] ld3;
  logic [2:0] ld4;
  logic [1:0] mode;
  logic       step_tick;

  modport master (
    output mode_req, pause,
    input  led, ld1, ld2, ld3, ld4,
    input  mode, step_tick
  );

  modport slave (
    input  mode_req, pause,
    output led, ld1, ld2, ld3, ld4,
    output mode, step_tick
  );
endinterface

// File: rtl/led_mode_scheduler.sv
// LED pattern scheduler: prescaled 4-mode FSM.
// LED_ACTIVE_LOW_EN inverts led/ld1..ld4 at the port.
module led_mode_scheduler #(
  parameter int TICK_DIV  = 12_000_000,
  parameter int MODE_HOLD = 16
) (
  input logic                 clk,
  input logic                 rst,
  led_mode_scheduler_if.slave bus
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (MODE_HOLD > 2) ? $clog2(MODE_HOLD) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] HOLD_MAX = SW'(MODE_HOLD - 1);

  typedef enum logic [1:0] {
    SHIFT_L  = 2'd0,
    SHIFT_R  = 2'd1,
    PINGPONG = 2'd2,
    BLINK    = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_L = 1'b0,
    DIR_R = 1'b1
  } dir_e;

  mode_e         mode_q, mode_d, mode_nxt;
  dir_e          pp_dir_q, pp_dir_d, dir_nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [7:0]    led_q, led_d;
  logic [2:0]    colour_q, colour_d;
  logic [2:0]    ld_q [4];
  logic [2:0]    ld_d [4];
  logic          step_tick_q, step_tick_d;
  logic          step;

  function automatic logic [7:0] start_pat(mode_e m);
    logic [7:0] p;
    unique case (m)
      SHIFT_L:  p = 8'h01;
      SHIFT_R:  p = 8'h80;
      PINGPONG: p = 8'h01;
      BLINK:    p = 8'hFF;
      default:  p = 8'h01;
    endcase
    return p;
  endfunction

  // Next-state: mode_req beats step events; pause freezes the rest.
  always_comb begin
    mode_d      = mode_q;
    pp_dir_d    = pp_dir_q;
    cnt_d       = cnt_q;
    step_cnt_d  = step_cnt_q;
    led_d       = led_q;
    colour_d    = colour_q;
    step_tick_d = 1'b0;
    mode_nxt    = mode_e'(mode_q + 2'd1);
    step        = !bus.pause && (cnt_q == CNT_MAX);

    dir_nxt = pp_dir_q;
    if (pp_dir_q == DIR_L && led_q == 8'h80)
      dir_nxt = DIR_R;
    else if (pp_dir_q == DIR_R && led_q == 8'h01)
      dir_nxt = DIR_L;

    if (bus.mode_req) begin
      mode_d     = mode_nxt;
      led_d      = start_pat(mode_nxt);
      pp_dir_d   = DIR_L;
      cnt_d      = '0;
      step_cnt_d = '0;
    end else if (step) begin
      cnt_d       = '0;
      step_tick_d = 1'b1;
      colour_d    = colour_q + 3'd1;
      if (step_cnt_q == HOLD_MAX) begin
        mode_d     = mode_nxt;
        led_d      = start_pat(mode_nxt);
        pp_dir_d   = DIR_L;
        step_cnt_d = '0;
      end else begin
        step_cnt_d = step_cnt_q + 1'b1;
        unique case (mode_q)
          SHIFT_L: led_d = {led_q[6:0], led_q[7]};
          SHIFT_R: led_d = {led_q[0], led_q[7:1]};
          PINGPONG: begin
            pp_dir_d = dir_nxt;
            led_d = (dir_nxt == DIR_L) ?
                    (led_q << 1) : (led_q >> 1);
          end
          BLINK:   led_d = ~led_q;
          default: led_d = led_q;
        endcase
      end
    end else if (!bus.pause) begin
      cnt_d = cnt_q + 1'b1;
    end

    for (int n = 0; n < 4; n++)
      ld_d[n] = colour_d + 3'(n);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= SHIFT_L;
      pp_dir_q    <= DIR_L;
      cnt_q       <= '0;
      step_cnt_q  <= '0;
      led_q       <= 8'h01;
      colour_q    <= 3'd0;
      step_tick_q <= 1'b0;
      for (int n = 0; n < 4; n++)
        ld_q[n] <= 3'(n);
    end else begin
      mode_q      <= mode_d;
      pp_dir_q    <= pp_dir_d;
      cnt_q       <= cnt_d;
      step_cnt_q  <= step_cnt_d;
      led_q       <= led_d;
      colour_q    <= colour_d;
      step_tick_q <= step_tick_d;
      for (int n = 0; n < 4; n++)
        ld_q[n] <= ld_d[n];
    end
  end

  assign bus.mode      = mode_q;
  assign bus.step_tick = step_tick_q;

`ifdef LED_ACTIVE_LOW_EN
  assign bus.led = ~led_q;
  assign bus.ld1 = ~ld_q[0];
  assign bus.ld2 = ~ld_q[1];
  assign bus.ld3 = ~ld_q[2];
  assign bus.ld4 = ~ld_q[3];
`else
  assign bus.led = led_q;
  assign bus.ld1 = ld_q[0];
  assign bus.ld2 = ld_q[1];
  assign bus.ld3 = ld_q[2];
  assign bus.ld4 = ld_q[3];
`endif
endmodule
